// File: rtl/map_tile_writer.sv
// Tile-map RAM writer: single-tile writes plus whole-map, row and column fills,
// one RAM write per cycle from registered outputs.
module map_tile_writer #(
   parameter int unsigned ROW_BITS  = 7,
   parameter int unsigned COL_BITS  = 7,
   parameter int unsigned TILE_BITS = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [ROW_BITS-1:0]          cmd_row,
   input  logic [COL_BITS-1:0]          cmd_col,
   input  logic [TILE_BITS-1:0]         cmd_tile,
   output logic                         mem_we,
   output logic [ROW_BITS+COL_BITS-1:0] mem_addr,
   output logic [TILE_BITS-1:0]         mem_din,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned AW = ROW_BITS + COL_BITS;
   localparam logic [AW-1:0] IdxOne = AW'(1);
   localparam logic [1:0] OpSingle = 2'b00;
   localparam logic [1:0] OpRow    = 2'b10;
   localparam logic [1:0] OpCol    = 2'b11;

   typedef enum logic [1:0] {IDLE, SINGLE, FILL} state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         idx_q, idx_d, idx_inc;
   logic [1:0]            op_q, op_d;
   logic [ROW_BITS-1:0]   row_q, row_d;
   logic [COL_BITS-1:0]   col_q, col_d;
   logic [TILE_BITS-1:0]  tile_q, tile_d;
   logic                  we_q, we_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [TILE_BITS-1:0]  din_q, din_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // idx walks the fill dimension; only its low bits matter for row/column fills.
   function automatic logic [AW-1:0] fill_addr(input logic [1:0]          op,
                                               input logic [ROW_BITS-1:0] row,
                                               input logic [COL_BITS-1:0] col,
                                               input logic [AW-1:0]       idx);
      case (op)
         OpRow:   fill_addr = {row, idx[COL_BITS-1:0]};
         OpCol:   fill_addr = {idx[ROW_BITS-1:0], col};
         default: fill_addr = idx;
      endcase
   endfunction

   function automatic logic fill_last(input logic [1:0] op, input logic [AW-1:0] idx);
      case (op)
         OpRow:   fill_last = &idx[COL_BITS-1:0];
         OpCol:   fill_last = &idx[ROW_BITS-1:0];
         default: fill_last = &idx;
      endcase
   endfunction

   assign idx_inc = idx_q + IdxOne;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      op_d    = op_q;
      row_d   = row_q;
      col_d   = col_q;
      tile_d  = tile_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               op_d   = cmd_op;
               row_d  = cmd_row;
               col_d  = cmd_col;
               tile_d = cmd_tile;
               idx_d  = '0;
               we_d   = 1'b1;
               din_d  = cmd_tile;
               busy_d = 1'b1;
               if (cmd_op == OpSingle) begin
                  state_d = SINGLE;
                  addr_d  = {cmd_row, cmd_col};
                  done_d  = 1'b1;
               end else begin
                  state_d = FILL;
                  addr_d  = fill_addr(cmd_op, cmd_row, cmd_col, '0);
                  done_d  = fill_last(cmd_op, '0);
               end
            end
         end
         SINGLE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         FILL: begin
            // Stop on the all-ones index so the wrapped index 0 is never written.
            if (fill_last(op_q, idx_q)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               idx_d  = idx_inc;
               we_d   = 1'b1;
               addr_d = fill_addr(op_q, row_q, col_q, idx_inc);
               din_d  = tile_q;
               done_d = fill_last(op_q, idx_inc);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         op_q    <= '0;
         row_q   <= '0;
         col_q   <= '0;
         tile_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         row_q   <= row_d;
         col_q   <= col_d;
         tile_q  <= tile_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_din   = din_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cmd_ready = ~busy_q;

endmodule

// File: doc/map_tile_writer.md
MAP_TILE_WRITER -- requirements
Module: map_tile_writer

Interface
REQ-001 SHALL have parameter ROW_BITS, default 7, meaning map row index width (128 rows).
REQ-002 SHALL have parameter COL_BITS, default 7, meaning map column index width (128 columns).
REQ-003 SHALL have parameter TILE_BITS, default 2, meaning tile code width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1, command request.
REQ-007 SHALL have port cmd_ready, output, 1, block can accept a command.
REQ-008 SHALL have port cmd_op, input, 2, operation: 00 single write, 01 fill map, 10 fill row, 11 fill column.
REQ-009 SHALL have port cmd_row, input, ROW_BITS, target row.
REQ-010 SHALL have port cmd_col, input, COL_BITS, target column.
REQ-011 SHALL have port cmd_tile, input, TILE_BITS, tile code to write.
REQ-012 SHALL have port mem_we, output, 1, write enable to the map RAM write port.
REQ-013 SHALL have port mem_addr, output, ROW_BITS+COL_BITS, RAM address; address = {row, col}.
REQ-014 SHALL have port mem_din, output, TILE_BITS, RAM write data.
REQ-015 SHALL have port busy, output, 1, a command is executing.
REQ-016 SHALL have port done, output, 1, one-cycle pulse on the final write of a command.

Function
REQ-017 SHALL have FSM states IDLE, SINGLE and FILL.
REQ-018 SHALL drive cmd_ready high only in IDLE; cmd_ready SHALL equal NOT busy.
REQ-019 SHALL accept a command on an edge where cmd_valid and cmd_ready are both high.
REQ-020 SHALL latch cmd_op, cmd_row, cmd_col and cmd_tile at acceptance; later changes on these inputs SHALL be ignored until the next acceptance.
REQ-021 SHALL register mem_we, mem_addr, mem_din, busy and done; none SHALL depend combinationally on inputs.
REQ-022 For op 00, if accepted at edge N, SHALL present mem_we=1, mem_addr={row,col} and mem_din=tile for exactly the cycle after edge N, with done=1 in that same cycle.
REQ-023 For op 01, SHALL write addresses 0 through 2^(ROW_BITS+COL_BITS)-1 in ascending order, one per cycle, with no gaps; the first write is in the cycle after acceptance.
REQ-024 For op 10, SHALL write {row, 0} through {row, 2^COL_BITS-1} in ascending column order, one per cycle.
REQ-025 For op 11, SHALL write {0, col} through {2^ROW_BITS-1, col} in ascending row order, one per cycle.
REQ-026 SHALL detect fill termination on the last index value (all ones) before the counter wraps; SHALL NOT emit a write at the wrapped index 0.
REQ-027 SHALL assert done together with mem_we on the last write of each command only, and SHALL return to IDLE on the following edge.
REQ-028 SHALL assert busy from the cycle after acceptance through the cycle of the last write inclusive.
REQ-029 A command whose cmd_valid is high on the edge the FSM enters IDLE SHALL be accepted on the next edge; back-to-back commands therefore have exactly one idle cycle between them.
REQ-030 SHALL hold mem_we=0 whenever no write is issued; mem_addr and mem_din SHALL hold their last values while mem_we=0.
REQ-031 SHALL issue exactly 1, 16384, 128 or 128 writes for op 00, 01, 10 or 11 respectively, at default parameters.

Reset
REQ-032 On reset assertion, SHALL immediately, regardless of clock, force state=IDLE, mem_we=0, mem_addr=0, mem_din=0, busy=0 and done=0.
REQ-033 A command interrupted by reset SHALL be abandoned; it SHALL NOT be resumed, and no done pulse SHALL be produced for it.
REQ-034 cmd_ready SHALL be 1 on the first cycle after reset deassertion.

Verification
REQ-035 Single write, row=5, col=9, tile=2 -> exactly one cycle with mem_we=1, mem_addr=0x0289, mem_din=2 and done=1; cmd_ready high again two cycles after acceptance.
REQ-036 Fill row, row=127, tile=1 -> 128 consecutive writes at addresses 0x3F80 through 0x3FFF; done only on 0x3FFF; no write to 0x0000.
REQ-037 Fill column, col=3, tile=3 -> writes at 0x0003, 0x0083, ... 0x3F83 (stride 128), 128 writes total.
REQ-038 Fill map, tile=0 -> 16384 consecutive writes at addresses 0 through 16383; busy high for 16384 cycles; one done pulse.
REQ-039 Reset asserted mid-fill-map at address 100 -> mem_we=0 and busy=0 asynchronously, no done pulse; a new single write afterwards completes normally.
REQ-040 cmd_tile and cmd_row changed during a fill row -> all writes use the values latched at acceptance; cmd_valid held high throughout -> the second command is accepted one idle cycle after done.
